// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Shares the single register-file write port between the WB stage
//            and a long-latency unit (LLU). One LLU result can be buffered.
//            WB normally has priority. A buffered LLU result that loses
//            MAX_WAIT times forces its way in, and WB is held for that cycle.
//            A 32-bit scoreboard tracks registers with outstanding LLU writes.
//            Decode is stalled on RAW/WAW hazards against those registers.
// Ports    : clk_i, reset_i (async, active-high)
//            wb_valid_i/wb_addr_i/wb_data_i   - WB write request
//            wb_hold_o                        - WB must hold / pipeline freeze
//            llu_valid_i/llu_addr_i/llu_data_i, llu_ready_o - LLU handshake
//            issue_valid_i/issue_llu_i/issue_dest_i/issue_rs1_i/issue_rs2_i
//            issue_stall_o                    - scoreboard hazard
//            rf_we_o/rf_waddr_o/rf_wdata_o    - registered RF write port
//            pending_o                        - scoreboard (bit 0 always 0)
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        wb_valid_i,
    input  logic [4:0]  wb_addr_i,
    input  logic [31:0] wb_data_i,
    output logic        wb_hold_o,
    input  logic        llu_valid_i,
    input  logic [4:0]  llu_addr_i,
    input  logic [31:0] llu_data_i,
    output logic        llu_ready_o,
    input  logic        issue_valid_i,
    input  logic        issue_llu_i,
    input  logic [4:0]  issue_dest_i,
    input  logic [4:0]  issue_rs1_i,
    input  logic [4:0]  issue_rs2_i,
    output logic        issue_stall_o,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic [31:0] pending_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // buffer empty
        PEND  = 2'd1,   // buffer full, WB has priority
        FORCE = 2'd2    // buffer full, LLU has priority
    } state_t;

    localparam logic [CNT_W-1:0] c_max_wait = CNT_W'(MAX_WAIT);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         buf_addr_q, buf_addr_d;
    logic [31:0]        buf_data_q, buf_data_d;
    logic [31:0]        pending_q, pending_d;
    logic               rf_we_q, rf_we_d;
    logic [4:0]         rf_waddr_q, rf_waddr_d;
    logic [31:0]        rf_wdata_q, rf_wdata_d;

    logic               w_llu_xfer;
    logic               w_grant_llu;
    logic               w_grant_wb;
    logic               w_issue_set;
    logic               w_hazard;
    logic [CNT_W-1:0]   w_cnt_inc;

    // ------------------------------------------------------------------
    // Handshake, grants and hazard detection
    // ------------------------------------------------------------------
    assign llu_ready_o = (state_q == IDLE);
    assign wb_hold_o   = (state_q == FORCE);
    assign w_llu_xfer  = llu_valid_i && (state_q == IDLE);

    // LLU wins when WB is idle or when it has waited long enough.
    assign w_grant_llu = ((state_q == PEND) && !wb_valid_i) || (state_q == FORCE);
    assign w_grant_wb  = wb_valid_i && (state_q != FORCE);

    // Only one LLU result may be outstanding, so an LLU issue also stalls
    // while the buffer is occupied.
    assign w_hazard = ((issue_rs1_i  != 5'd0) && pending_q[issue_rs1_i])  ||
                      ((issue_rs2_i  != 5'd0) && pending_q[issue_rs2_i])  ||
                      ((issue_dest_i != 5'd0) && pending_q[issue_dest_i]) ||
                      (issue_llu_i && (state_q != IDLE));

    assign issue_stall_o = issue_valid_i && w_hazard;
    assign w_issue_set   = issue_valid_i && issue_llu_i && !w_hazard &&
                           (issue_dest_i != 5'd0);

    assign w_cnt_inc = cnt_q + CNT_W'(1);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        pending_d  = pending_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;

        case (state_q)
            IDLE: begin
                if (w_llu_xfer) begin
                    state_d    = PEND;
                    cnt_d      = '0;
                    buf_addr_d = llu_addr_i;
                    buf_data_d = llu_data_i;
                end
            end
            PEND: begin
                if (!wb_valid_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = w_cnt_inc;
                    if (w_cnt_inc == c_max_wait) begin
                        state_d = FORCE;
                    end
                end
            end
            FORCE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A write to r0 still consumes its grant but never reaches the RF.
        if (w_grant_llu) begin
            rf_we_d               = (buf_addr_q != 5'd0);
            rf_waddr_d            = buf_addr_q;
            rf_wdata_d            = buf_data_q;
            pending_d[buf_addr_q] = 1'b0;
        end else if (w_grant_wb) begin
            rf_we_d    = (wb_addr_i != 5'd0);
            rf_waddr_d = wb_addr_i;
            rf_wdata_d = wb_data_i;
        end

        // Applied after the clear so a same-register set wins.
        if (w_issue_set) begin
            pending_d[issue_dest_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            buf_addr_q <= '0;
            buf_data_q <= '0;
            pending_q  <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
            pending_q  <= pending_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we_o    = rf_we_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wdata_o = rf_wdata_q;
    assign pending_o  = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Purpose  : Self-checking bench for regfile_write_arbiter. A behavioural
//            model (buffer occupancy, loss count, scoreboard array) predicts
//            every output each cycle; directed scenarios add literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wb_valid, llu_valid, issue_valid, issue_llu;
    logic [4:0]  wb_addr, llu_addr, issue_dest, issue_rs1, issue_rs2;
    logic [31:0] wb_data, llu_data;
    logic        wb_hold, llu_ready, issue_stall, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, pending;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic        m_full;
    logic [4:0]  m_baddr;
    logic [31:0] m_bdata;
    int          m_losses;
    logic [31:0] m_pend;
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    regfile_write_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut (
        .clk_i(clk), .reset_i(reset),
        .wb_valid_i(wb_valid), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
        .wb_hold_o(wb_hold),
        .llu_valid_i(llu_valid), .llu_addr_i(llu_addr), .llu_data_i(llu_data),
        .llu_ready_o(llu_ready),
        .issue_valid_i(issue_valid), .issue_llu_i(issue_llu),
        .issue_dest_i(issue_dest), .issue_rs1_i(issue_rs1), .issue_rs2_i(issue_rs2),
        .issue_stall_o(issue_stall),
        .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
        .pending_o(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_in();
        wb_valid = 0; wb_addr = 0; wb_data = 0;
        llu_valid = 0; llu_addr = 0; llu_data = 0;
        issue_valid = 0; issue_llu = 0; issue_dest = 0; issue_rs1 = 0; issue_rs2 = 0;
    endtask

    task automatic model_reset();
        m_full = 0; m_baddr = 0; m_bdata = 0; m_losses = 0;
        m_pend = 0; m_we = 0; m_waddr = 0; m_wdata = 0;
    endtask

    function automatic logic exp_stall();
        if (!issue_valid) return 1'b0;
        return (issue_rs1  != 0 && m_pend[issue_rs1])  ||
               (issue_rs2  != 0 && m_pend[issue_rs2])  ||
               (issue_dest != 0 && m_pend[issue_dest]) ||
               (issue_llu && m_full);
    endfunction

    task automatic compare();
        chk("llu_ready",   llu_ready,   !m_full);
        chk("wb_hold",     wb_hold,     m_full && (m_losses == MAX_WAIT));
        chk("issue_stall", issue_stall, exp_stall());
        chk("pending",     pending,     m_pend);
        chk("rf_we",       rf_we,       m_we);
        if (m_we) begin
            chk("rf_waddr", rf_waddr, m_waddr);
            chk("rf_wdata", rf_wdata, m_wdata);
        end
    endtask

    // Advance the model across the coming rising edge using current inputs.
    task automatic model_step();
        logic        xfer, llu_wins, wb_wins, set;
        logic [31:0] np;
        xfer     = !m_full && llu_valid;
        llu_wins = m_full && ((m_losses == MAX_WAIT) || !wb_valid);
        wb_wins  = wb_valid && !llu_wins;
        set      = issue_valid && issue_llu && !exp_stall() && (issue_dest != 0);
        np       = m_pend;
        if (llu_wins) begin
            m_we = (m_baddr != 0); m_waddr = m_baddr; m_wdata = m_bdata;
            np[m_baddr] = 1'b0;
            m_full = 0; m_losses = 0;
        end else if (wb_wins) begin
            m_we = (wb_addr != 0); m_waddr = wb_addr; m_wdata = wb_data;
            if (m_full) m_losses++;
        end else begin
            m_we = 0;
        end
        if (xfer) begin
            m_full = 1; m_baddr = llu_addr; m_bdata = llu_data; m_losses = 0;
        end
        if (set) np[issue_dest] = 1'b1;
        np[0] = 1'b0;
        m_pend = np;
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic cycle();
        #1;
        compare();
        model_step();
        @(negedge clk);
    endtask

    initial begin
        idle_in();
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_pending", pending, 0);
        chk("rst_llu_ready", llu_ready, 1);
        chk("rst_wb_hold", wb_hold, 0);
        reset = 0;

        // WB alone
        wb_valid = 1; wb_addr = 5; wb_data = 32'hDEADBEEF;
        cycle();
        chk("wb_we", rf_we, 1);
        chk("wb_addr", rf_waddr, 5);
        chk("wb_data", rf_wdata, 32'hDEADBEEF);
        wb_addr = 0; wb_data = 32'h1111_2222;
        cycle();
        chk("wb_r0_we", rf_we, 0);
        idle_in();

        // LLU alone: issue to r7, hazard, result, release
        issue_valid = 1; issue_llu = 1; issue_dest = 7; issue_rs1 = 1; issue_rs2 = 2;
        cycle();
        chk("pend7_set", pending[7], 1);
        issue_llu = 0; issue_rs1 = 7; issue_dest = 8;
        #1 chk("raw_stall7", issue_stall, 1);
        cycle();
        idle_in();
        llu_valid = 1; llu_addr = 7; llu_data = 32'h12;
        cycle();
        chk("llu_taken_ready", llu_ready, 0);
        idle_in();
        cycle();
        chk("llu_we", rf_we, 1);
        chk("llu_addr", rf_waddr, 7);
        chk("llu_data", rf_wdata, 32'h12);
        chk("pend7_clr", pending[7], 0);
        issue_valid = 1; issue_rs1 = 7; issue_dest = 8;
        #1 chk("raw_stall7_gone", issue_stall, 0);
        cycle();
        idle_in();

        // Collision: WB continuously valid while the buffer is full
        llu_valid = 1; llu_addr = 10; llu_data = 32'hAAAA0001;
        wb_valid = 1; wb_addr = 4; wb_data = 32'h100;
        cycle();
        llu_valid = 0;
        for (int i = 0; i < MAX_WAIT; i++) begin
            wb_data = 32'h200 + i;
            #1 chk("coll_no_hold", wb_hold, 0);
            cycle();
            chk("coll_wb_data", rf_wdata, 32'h200 + i);
            chk("coll_wb_we", rf_we, 1);
        end
        wb_data = 32'h300;
        #1 chk("coll_hold", wb_hold, 1);
        cycle();
        chk("coll_llu_we", rf_we, 1);
        chk("coll_llu_addr", rf_waddr, 10);
        chk("coll_llu_data", rf_wdata, 32'hAAAA0001);
        #1 chk("coll_hold_off", wb_hold, 0);
        cycle();
        chk("coll_wb_resume", rf_wdata, 32'h300);
        idle_in();

        // Grant for r9 coinciding with an LLU issue to r9
        issue_valid = 1; issue_llu = 1; issue_dest = 9;
        cycle();
        idle_in();
        llu_valid = 1; llu_addr = 9; llu_data = 32'h99;
        cycle();
        idle_in();
        issue_valid = 1; issue_llu = 1; issue_dest = 9;
        #1 chk("r9_issue_stall", issue_stall, 1);
        cycle();
        idle_in();
        cycle();

        // Reset mid-operation with a buffered LLU result for r3
        issue_valid = 1; issue_llu = 1; issue_dest = 3;
        cycle();
        idle_in();
        llu_valid = 1; llu_addr = 3; llu_data = 32'h33;
        wb_valid = 1; wb_addr = 6; wb_data = 32'h66;
        cycle();
        llu_valid = 0;
        cycle();
        chk("pre_rst_we", rf_we, 1);
        chk("pre_rst_pend3", pending[3], 1);
        #2 reset = 1;
        #1;
        chk("arst_rf_we", rf_we, 0);
        chk("arst_pending", pending, 0);
        chk("arst_llu_ready", llu_ready, 1);
        model_reset();
        idle_in();
        @(negedge clk);
        reset = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("post_rst_no_write", rf_we, 0);
        end

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            wb_valid    = ($urandom_range(0, 9) < ((n < 400) ? 8 : 4));
            wb_addr     = 5'($urandom_range(0, 7));
            wb_data     = $urandom;
            llu_valid   = ($urandom_range(0, 2) == 0);
            llu_addr    = 5'($urandom_range(0, 7));
            llu_data    = $urandom;
            issue_valid = $urandom_range(0, 1);
            issue_llu   = $urandom_range(0, 1);
            issue_dest  = 5'($urandom_range(0, 7));
            issue_rs1   = 5'($urandom_range(0, 7));
            issue_rs2   = 5'($urandom_range(0, 7));
            cycle();
        end
        idle_in();
        #1 compare();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
